// File: rtl/reg_bank_pkg.sv
// Shared CPU constants: zero-register index, stack-pointer defaults and the
// destination-select encoding that feeds the register-bank write address.
package reg_bank_pkg;

    localparam int REG_ZERO     = 0;
    localparam int REG_RA       = 31;
    localparam int SP_IDX_DEF   = 29;
    localparam int SP_RESET_DEF = 227;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } dst_sel_e;

    // Write-address mux used ahead of the bank (jal-style link goes to RA).
    function automatic logic [4:0] dst_index(input dst_sel_e sel,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
        case (sel)
            DST_RT:  dst_index = rt;
            DST_RD:  dst_index = rd;
            DST_RA:  dst_index = 5'(REG_RA);
            default: dst_index = 5'(REG_ZERO);
        endcase
    endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port of the register bank.
// REG_BANK_BYPASS_EN: forward same-edge write data (write-first); otherwise read-first.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int NREG  = 1 << ADDR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NREG-1:0][DATA_W-1:0]    regs,
    input  logic [ADDR_W-1:0]              rd_addr,
    input  logic                           reg_wr,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    output logic [DATA_W-1:0]              rd_data
);

    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              hit;

`ifdef REG_BANK_BYPASS_EN
    assign hit = reg_wr && (wr_addr == rd_addr) && (wr_addr != ADDR_W'(REG_ZERO));
`else
    logic unused_wr;
    assign unused_wr = ^{reg_wr, wr_addr, wr_data};
    assign hit       = 1'b0;
`endif

    always_comb begin
        rd_data_d = regs[rd_addr];
        if (hit) rd_data_d = wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rd_data_q <= '0;
        else        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/reg_bank.sv
// Two-read, one-write register bank with hard-wired zero register and a
// stack pointer that resets to SP_RESET. Collision policy: REG_BANK_BYPASS_EN.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int SP_IDX   = SP_IDX_DEF,
    parameter int SP_RESET = SP_RESET_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_wr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] regs_d, regs_q;

    always_comb begin
        regs_d = regs_q;
        if (reg_wr && (wr_addr != ADDR_W'(REG_ZERO))) regs_d[wr_addr] = wr_data;
        regs_d[REG_ZERO] = '0;
    end

    // The zero slot never takes the SP reset value even if SP_IDX is misconfigured.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= (i == SP_IDX && i != REG_ZERO) ? DATA_W'(SP_RESET) : '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_a (
        .clk     (clk),
        .reset   (reset),
        .regs    (regs_q),
        .rd_addr (rd_addr_a),
        .reg_wr  (reg_wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_a)
    );

    reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd_b (
        .clk     (clk),
        .reset   (reset),
        .regs    (regs_q),
        .rd_addr (rd_addr_b),
        .reg_wr  (reg_wr),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_b)
    );

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank against an array-based register model.
module tb_reg_bank;

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_wr = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a, rd_data_b;

    logic [31:0] model [32];
    logic [31:0] exp_a, exp_b;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    reg_bank dut (
        .clk       (clk),
        .reset     (reset),
        .reg_wr    (reg_wr),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = '0;
        model[29] = 32'd227;
    endtask

    // One clock: drive at negedge, predict from the model, sample 1 time unit after posedge.
    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb);
        @(negedge clk);
        reg_wr = w; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
        exp_a = model[ra];
        exp_b = model[rb];
        if (BYP && w && wa != 0) begin
            if (wa == ra) exp_a = wd;
            if (wa == rb) exp_b = wd;
        end
        @(posedge clk);
        if (w && wa != 0) model[wa] = wd;
        #1;
        reg_wr = 1'b0;
    endtask

    task automatic test_reset();
        #3 reset = 1'b0;
        #1;
        n_cmp++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            n_err++;
            $display("FAIL reset_async_out: got a=%h b=%h, required 0/0", rd_data_a, rd_data_b);
        end
        // A write held across edges during reset must be lost.
        reg_wr = 1'b1; wr_addr = 5'd8; wr_data = 32'hCAFE_F00D;
        rd_addr_a = 5'd29; rd_addr_b = 5'd8;
        @(posedge clk); #1;
        n_cmp++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hold_out: got a=%h b=%h, required 0/0", rd_data_a, rd_data_b);
        end
        @(posedge clk);
        @(negedge clk);
        reg_wr = 1'b0;
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i));
            n_cmp++;
            if (rd_data_a !== exp_a || rd_data_b !== exp_b) begin
                n_err++;
                $display("FAIL reset_value[%0d]: got a=%h b=%h, required a=%h b=%h",
                         i, rd_data_a, rd_data_b, exp_a, exp_b);
            end
        end
        n_cmp++;
        if (model[29] !== 32'd227 || model[8] !== 32'd0) begin
            n_err++;
            $display("FAIL reset_model: got r29=%h r8=%h, required 000000e3/0", model[29], model[8]);
        end
    endtask

    task automatic test_basic_write();
        step(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 5'd8, 5'd29);
        n_cmp++;
        if (rd_data_a !== 32'hDEAD_BEEF || rd_data_b !== 32'd227) begin
            n_err++;
            $display("FAIL basic_write: got a=%h b=%h, required deadbeef/000000e3", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_zero_reg();
        step(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
        n_cmp++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            n_err++;
            $display("FAIL zero_same_edge: got a=%h b=%h, required 0/0", rd_data_a, rd_data_b);
        end
        step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        n_cmp++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            n_err++;
            $display("FAIL zero_reg: got a=%h b=%h, required 0/0", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_collision();
        logic [31:0] want;
        want = BYP ? 32'h22 : 32'h11;
        step(1'b1, 5'd5, 32'h11, 5'd0, 5'd0);
        step(1'b1, 5'd5, 32'h22, 5'd5, 5'd6);
        n_cmp++;
        if (rd_data_a !== want || rd_data_a !== exp_a) begin
            n_err++;
            $display("FAIL collision: got %h, required %h", rd_data_a, want);
        end
        step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        n_cmp++;
        if (rd_data_a !== 32'h22 || rd_data_b !== 32'h22) begin
            n_err++;
            $display("FAIL collision_next: got a=%h b=%h, required 22/22", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_dual_port();
        step(1'b1, 5'd3, 32'hA, 5'd0, 5'd0);
        step(1'b1, 5'd4, 32'hB, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
        n_cmp++;
        if (rd_data_a !== 32'hA || rd_data_b !== 32'hB) begin
            n_err++;
            $display("FAIL dual_port: got a=%h b=%h, required a/b", rd_data_a, rd_data_b);
        end
        step(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        n_cmp++;
        if (rd_data_a !== 32'hA || rd_data_b !== 32'hA) begin
            n_err++;
            $display("FAIL dual_same_addr: got a=%h b=%h, required a/a", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_random();
        logic        w;
        logic [4:0]  wa, ra, rb;
        logic [31:0] wd;
        for (int n = 0; n < 400; n++) begin
            w  = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rb = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wd = $urandom;
            step(w, wa, wd, ra, rb);
            n_cmp++;
            if (rd_data_a !== exp_a || rd_data_b !== exp_b) begin
                n_err++;
                $display("FAIL random[%0d]: got a=%h b=%h, required a=%h b=%h (wr=%0d wa=%0d ra=%0d rb=%0d)",
                         n, rd_data_a, rd_data_b, exp_a, exp_b, w, wa, ra, rb);
            end
        end
    endtask

    task automatic test_midrun_reset();
        step(1'b1, 5'd9, 32'h9999_0009, 5'd0, 5'd0);
        step(1'b0, 5'd0, 32'd0, 5'd9, 5'd29);
        n_cmp++;
        if (rd_data_a !== 32'h9999_0009) begin
            n_err++;
            $display("FAIL midrun_pre: got %h, required 99990009", rd_data_a);
        end
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            n_err++;
            $display("FAIL midrun_async: got a=%h b=%h, required 0/0", rd_data_a, rd_data_b);
        end
        #1 reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd0) begin
            n_err++;
            $display("FAIL midrun_released: got a=%h b=%h, required 0/0", rd_data_a, rd_data_b);
        end
        step(1'b0, 5'd0, 32'd0, 5'd9, 5'd29);
        n_cmp++;
        if (rd_data_a !== 32'd0 || rd_data_b !== 32'd227) begin
            n_err++;
            $display("FAIL midrun_after: got a=%h b=%h, required 0/000000e3", rd_data_a, rd_data_b);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic_write();
        test_zero_reg();
        test_collision();
        test_dual_port();
        test_random();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
